// File: rtl/mm_wb_skid_pkg.sv
//------------------------------------------------------------------------------
// mm_wb_skid_pkg : shared state encoding and capture helper for mm_wb_skid
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mm_wb_skid_pkg;

    // The encoding equals the entry count, so the occupancy output is the state.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic logic capture_regwrite(
        input logic regwrite,
        input logic regdst_is_zero,
        input logic guard
    );
        return regwrite && !(guard && regdst_is_zero);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mm_wb_entry.sv
//------------------------------------------------------------------------------
// mm_wb_entry : one MEM/WB payload register with load enable and source select
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mm_wb_entry #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sel_alt,
    input  logic [DATA_W-1:0] in_mmdata,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_W-1:0]  in_regdst,
    input  logic              in_memtoreg,
    input  logic              in_regwrite,
    input  logic [DATA_W-1:0] alt_mmdata,
    input  logic [DATA_W-1:0] alt_result,
    input  logic [REG_W-1:0]  alt_regdst,
    input  logic              alt_memtoreg,
    input  logic              alt_regwrite,
    output logic [DATA_W-1:0] q_mmdata,
    output logic [DATA_W-1:0] q_result,
    output logic [REG_W-1:0]  q_regdst,
    output logic              q_memtoreg,
    output logic              q_regwrite
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_mmdata   <= '0;
            q_result   <= '0;
            q_regdst   <= '0;
            q_memtoreg <= 1'b0;
            q_regwrite <= 1'b0;
        end else if (load) begin
            q_mmdata   <= sel_alt ? alt_mmdata   : in_mmdata;
            q_result   <= sel_alt ? alt_result   : in_result;
            q_regdst   <= sel_alt ? alt_regdst   : in_regdst;
            q_memtoreg <= sel_alt ? alt_memtoreg : in_memtoreg;
            q_regwrite <= sel_alt ? alt_regwrite : in_regwrite;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mm_wb_skid.sv
//------------------------------------------------------------------------------
// mm_wb_skid : MEM/WB pipeline stage with valid/ready handshake and 2-entry skid
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mm_wb_skid
    import mm_wb_skid_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int ZERO_GUARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mm_valid,
    output logic              mm_ready,
    input  logic [DATA_W-1:0] mm_mmdata,
    input  logic [DATA_W-1:0] mm_result,
    input  logic [REG_W-1:0]  mm_regdst,
    input  logic              mm_memtoreg,
    input  logic              mm_regwrite,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_mmdata,
    output logic [DATA_W-1:0] wb_result,
    output logic [REG_W-1:0]  wb_regdst,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic [1:0]        wb_occupancy
);

    localparam logic GUARD_EN = (ZERO_GUARD != 0);

    skid_state_e       state;
    logic              accept;
    logic              consume;
    logic              cap_regwrite;
    logic              main_load;
    logic              main_sel_skid;
    logic              skid_load;
    logic              main_regwrite;
    logic [DATA_W-1:0] skid_mmdata;
    logic [DATA_W-1:0] skid_result;
    logic [REG_W-1:0]  skid_regdst;
    logic              skid_memtoreg;
    logic              skid_regwrite;

    assign mm_ready     = (state != SKID_FULL);
    assign wb_valid     = (state != SKID_EMPTY);
    assign wb_occupancy = state;
    assign wb_regwrite  = main_regwrite && wb_valid;

    assign accept  = mm_valid && mm_ready;
    assign consume = wb_valid && wb_ready;

    assign cap_regwrite = capture_regwrite(mm_regwrite, (mm_regdst == '0), GUARD_EN);

    // Payload loads are suppressed on flush so held data cannot be replaced by the dropped input.
    assign main_load     = !flush && (((state == SKID_EMPTY) && accept) ||
                                      ((state == SKID_ONE)   && accept && consume) ||
                                      ((state == SKID_FULL)  && consume));
    assign main_sel_skid = (state == SKID_FULL);
    assign skid_load     = !flush && (state == SKID_ONE) && accept && !consume;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SKID_EMPTY;
        end else if (flush) begin
            state <= SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: if (accept) state <= SKID_ONE;
                SKID_ONE: begin
                    if (accept && !consume)      state <= SKID_FULL;
                    else if (!accept && consume) state <= SKID_EMPTY;
                end
                SKID_FULL:  if (consume) state <= SKID_ONE;
                default:    state <= SKID_EMPTY;
            endcase
        end
    end

    mm_wb_entry #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_main (
        .clk          (clk),
        .rst          (rst),
        .load         (main_load),
        .sel_alt      (main_sel_skid),
        .in_mmdata    (mm_mmdata),
        .in_result    (mm_result),
        .in_regdst    (mm_regdst),
        .in_memtoreg  (mm_memtoreg),
        .in_regwrite  (cap_regwrite),
        .alt_mmdata   (skid_mmdata),
        .alt_result   (skid_result),
        .alt_regdst   (skid_regdst),
        .alt_memtoreg (skid_memtoreg),
        .alt_regwrite (skid_regwrite),
        .q_mmdata     (wb_mmdata),
        .q_result     (wb_result),
        .q_regdst     (wb_regdst),
        .q_memtoreg   (wb_memtoreg),
        .q_regwrite   (main_regwrite)
    );

    mm_wb_entry #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .load         (skid_load),
        .sel_alt      (1'b0),
        .in_mmdata    (mm_mmdata),
        .in_result    (mm_result),
        .in_regdst    (mm_regdst),
        .in_memtoreg  (mm_memtoreg),
        .in_regwrite  (cap_regwrite),
        .alt_mmdata   ('0),
        .alt_result   ('0),
        .alt_regdst   ('0),
        .alt_memtoreg (1'b0),
        .alt_regwrite (1'b0),
        .q_mmdata     (skid_mmdata),
        .q_result     (skid_result),
        .q_regdst     (skid_regdst),
        .q_memtoreg   (skid_memtoreg),
        .q_regwrite   (skid_regwrite)
    );

endmodule

`default_nettype wire

// File: tb/tb_mm_wb_skid.sv
//------------------------------------------------------------------------------
// tb_mm_wb_skid : directed stimulus, queue model and per-cycle compare
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mm_wb_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        mm_valid;
    logic [31:0] mm_mmdata;
    logic [31:0] mm_result;
    logic [4:0]  mm_regdst;
    logic        mm_memtoreg;
    logic        mm_regwrite;
    logic        flush;
    logic        wb_ready;

    logic        mm_ready,  mm_ready_n;
    logic        wb_valid,  wb_valid_n;
    logic [31:0] wb_mmdata, wb_mmdata_n;
    logic [31:0] wb_result, wb_result_n;
    logic [4:0]  wb_regdst, wb_regdst_n;
    logic        wb_memtoreg, wb_memtoreg_n;
    logic        wb_regwrite, wb_regwrite_n;
    logic [1:0]  wb_occ, wb_occ_n;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    mm_wb_skid #(.DATA_W(32), .REG_W(5), .ZERO_GUARD(1)) dut (
        .clk(clk), .rst(rst), .mm_valid(mm_valid), .mm_ready(mm_ready),
        .mm_mmdata(mm_mmdata), .mm_result(mm_result), .mm_regdst(mm_regdst),
        .mm_memtoreg(mm_memtoreg), .mm_regwrite(mm_regwrite), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_mmdata(wb_mmdata),
        .wb_result(wb_result), .wb_regdst(wb_regdst), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite), .wb_occupancy(wb_occ)
    );

    mm_wb_skid #(.DATA_W(32), .REG_W(5), .ZERO_GUARD(0)) dut_ng (
        .clk(clk), .rst(rst), .mm_valid(mm_valid), .mm_ready(mm_ready_n),
        .mm_mmdata(mm_mmdata), .mm_result(mm_result), .mm_regdst(mm_regdst),
        .mm_memtoreg(mm_memtoreg), .mm_regwrite(mm_regwrite), .flush(flush),
        .wb_valid(wb_valid_n), .wb_ready(wb_ready), .wb_mmdata(wb_mmdata_n),
        .wb_result(wb_result_n), .wb_regdst(wb_regdst_n), .wb_memtoreg(wb_memtoreg_n),
        .wb_regwrite(wb_regwrite_n), .wb_occupancy(wb_occ_n)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of at most two entries.
    typedef struct {
        logic [31:0] mmdata;
        logic [31:0] result;
        logic [4:0]  regdst;
        logic        memtoreg;
        logic        rw_guard;
        logic        rw_plain;
    } ent_t;

    ent_t q[$];

    always @(posedge clk) begin
        if (!rst || flush) begin
            q.delete();
        end else begin
            bit cons;
            bit acc;
            ent_t e;
            cons = (q.size() > 0) && wb_ready;
            acc  = mm_valid && (q.size() < 2);
            if (cons) void'(q.pop_front());
            if (acc) begin
                e.mmdata   = mm_mmdata;
                e.result   = mm_result;
                e.regdst   = mm_regdst;
                e.memtoreg = mm_memtoreg;
                e.rw_guard = mm_regwrite && (mm_regdst != 5'd0);
                e.rw_plain = mm_regwrite;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mm_ready",      {63'd0, mm_ready},    {63'd0, q.size() < 2});
            chk("wb_valid",      {63'd0, wb_valid},    {63'd0, q.size() > 0});
            chk("occupancy",     {62'd0, wb_occ},      64'(q.size()));
            chk("occupancy_ng",  {62'd0, wb_occ_n},    64'(q.size()));
            chk("wb_regwrite",   {63'd0, wb_regwrite},   {63'd0, (q.size() > 0) && q[0].rw_guard});
            chk("wb_regwrite_ng",{63'd0, wb_regwrite_n}, {63'd0, (q.size() > 0) && q[0].rw_plain});
            if (q.size() > 0) begin
                chk("wb_result",   {32'd0, wb_result}, {32'd0, q[0].result});
                chk("wb_mmdata",   {32'd0, wb_mmdata}, {32'd0, q[0].mmdata});
                chk("wb_regdst",   {59'd0, wb_regdst}, {59'd0, q[0].regdst});
                chk("wb_memtoreg", {63'd0, wb_memtoreg}, {63'd0, q[0].memtoreg});
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] dst,
                         input logic rw, input logic wr, input logic fl);
        mm_valid    = v;
        mm_result   = res;
        mm_mmdata   = res ^ 32'hFFFF_0000;
        mm_regdst   = dst;
        mm_memtoreg = res[0];
        mm_regwrite = rw;
        wb_ready    = wr;
        flush       = fl;
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"},    {63'd0, wb_valid},    64'd0);
        chk({tag, "_regwrite"}, {63'd0, wb_regwrite}, 64'd0);
        chk({tag, "_memtoreg"}, {63'd0, wb_memtoreg}, 64'd0);
        chk({tag, "_occ"},      {62'd0, wb_occ},      64'd0);
        chk({tag, "_result"},   {32'd0, wb_result},   64'd0);
        chk({tag, "_mmdata"},   {32'd0, wb_mmdata},   64'd0);
        chk({tag, "_regdst"},   {59'd0, wb_regdst},   64'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 32'hDEAD, 5'd7, 1'b1, 1'b1, 1'b0);
        started = 1'b1;
        drive(1'b1, 32'hBEEF, 5'd7, 1'b1, 1'b1, 1'b0);
        chk_reset_values("reset");
        chk("reset_ready", {63'd0, mm_ready}, 64'd1);

        // Streaming with wb_ready held high.
        rst = 1'b1;
        drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 1'b0);
        chk("stream_11", {32'd0, wb_result}, 64'h11);
        chk("stream_occ", {62'd0, wb_occ}, 64'd1);
        drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 1'b0);
        chk("stream_22", {32'd0, wb_result}, 64'h22);
        drive(1'b1, 32'h33, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("stream_33", {32'd0, wb_result}, 64'h33);
        chk("stream_ready", {63'd0, mm_ready}, 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("stream_drained", {63'd0, wb_valid}, 64'd0);

        // Backpressure into the skid entry, then drain.
        drive(1'b1, 32'hA0, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("bp_occ1", {62'd0, wb_occ}, 64'd1);
        drive(1'b1, 32'hA1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("bp_occ2", {62'd0, wb_occ}, 64'd2);
        chk("bp_ready0", {63'd0, mm_ready}, 64'd0);
        chk("bp_hold_a0", {32'd0, wb_result}, 64'hA0);
        drive(1'b1, 32'hA2, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("bp_stable_a0", {32'd0, wb_result}, 64'hA0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_drain_a1", {32'd0, wb_result}, 64'hA1);
        chk("bp_ready1", {63'd0, mm_ready}, 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_empty", {62'd0, wb_occ}, 64'd0);

        // Accept and consume together while ONE.
        drive(1'b1, 32'h5, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("sim_hold_5", {32'd0, wb_result}, 64'h5);
        drive(1'b1, 32'h6, 5'd9, 1'b1, 1'b1, 1'b0);
        chk("sim_6", {32'd0, wb_result}, 64'h6);
        chk("sim_occ", {62'd0, wb_occ}, 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Register-zero write guard, both parameterisations.
        drive(1'b1, 32'h70, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("zg_dst0_guard", {63'd0, wb_regwrite}, 64'd0);
        chk("zg_dst0_plain", {63'd0, wb_regwrite_n}, 64'd1);
        drive(1'b1, 32'h71, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("zg_dst3_guard", {63'd0, wb_regwrite}, 64'd1);
        chk("zg_dst3_plain", {63'd0, wb_regwrite_n}, 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Flush from FULL with a pending input.
        drive(1'b1, 32'hB0, 5'd10, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hB1, 5'd11, 1'b1, 1'b0, 1'b0);
        chk("fl_full", {62'd0, wb_occ}, 64'd2);
        drive(1'b1, 32'hB2, 5'd12, 1'b1, 1'b0, 1'b1);
        chk("fl_valid", {63'd0, wb_valid}, 64'd0);
        chk("fl_regwrite", {63'd0, wb_regwrite}, 64'd0);
        chk("fl_occ", {62'd0, wb_occ}, 64'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("fl_not_delivered", {63'd0, wb_valid}, 64'd0);

        // Reset while stalled in FULL.
        drive(1'b1, 32'hC0, 5'd13, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hC1, 5'd14, 1'b1, 1'b0, 1'b0);
        chk("rs_full", {62'd0, wb_occ}, 64'd2);
        rst = 1'b0;
        drive(1'b1, 32'hC2, 5'd15, 1'b1, 1'b0, 1'b0);
        chk_reset_values("midreset");
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rs_ready_after", {63'd0, mm_ready}, 64'd1);
        chk("rs_valid_after", {63'd0, wb_valid}, 64'd0);

        // Brief mixed traffic so the model compare covers skid refill paths.
        drive(1'b1, 32'hD0, 5'd1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'hD1, 5'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hD2, 5'd3, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'hD3, 5'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
